// File: rtl/ddr_rd_burst_ctrl.sv
// AXI4 read master: splits (address, beat count) commands into 4 KB-safe INCR bursts,
// bounds outstanding bursts and forwards R data unbuffered. Optional macro: DDR_RD_RRESP_CHECK_EN.
module ddr_rd_burst_ctrl #(
  parameter int ADDR_W          = 34,
  parameter int DATA_W          = 512,
  parameter int LEN_W           = 20,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              core_clk,
  input  logic              sys_rst,
  input  logic              calib_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last,
  output logic              done,
  output logic              rd_err
);

  localparam int BPB    = DATA_W / 8;
  localparam int BSH    = $clog2(BPB);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int SIZE_W = 9;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0]    out_q, out_d;
  logic                arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [7:0]          arlen_q, arlen_d;
  logic                done_q, done_d;
  logic                rd_err_q, rd_err_d;

  logic                active, ar_hs, r_hs, r_last_hs, final_hs;
  logic [ADDR_W-1:0]   src_addr, ld_next;
  logic [LEN_W-1:0]    src_remain, ld_remain;
  logic [12:0]         beats_4k;
  logic [SIZE_W-1:0]   size_c;

  assign active     = (state_q != IDLE);
  assign cmd_ready  = (state_q == IDLE) & calib_done & ~sys_rst;
  assign m_rready   = active & dout_ready;
  assign dout_valid = active & m_rvalid;
  assign dout_data  = m_rdata;
  assign dout_last  = active & (beat_q == len_q - LEN_W'(1));
  assign ar_hs      = arvalid_q & m_arready;
  assign r_hs       = active & m_rvalid & dout_ready;
  assign r_last_hs  = r_hs & m_rlast;
  assign final_hs   = r_hs & dout_last;

  assign m_arvalid  = arvalid_q;
  assign m_araddr   = araddr_q;
  assign m_arlen    = arlen_q;
  assign m_arsize   = 3'(BSH);
  assign m_arburst  = 2'b01;
  assign done       = done_q;
  assign rd_err     = rd_err_q;

  // The first burst is sized straight from the command so AR goes out the cycle after accept.
  always_comb begin
    src_addr   = (state_q == IDLE) ? (cmd_addr & ~ADDR_W'(BPB - 1)) : addr_q;
    src_remain = (state_q == IDLE) ? cmd_len : remain_q;
    beats_4k   = 13'(4096 >> BSH) - 13'(src_addr[11:BSH]);
    size_c     = SIZE_W'(MAX_BURST);
    if (13'(size_c) > beats_4k)      size_c = SIZE_W'(beats_4k);
    if (LEN_W'(size_c) > src_remain) size_c = SIZE_W'(src_remain);
    ld_next    = src_addr + (ADDR_W'(size_c) << BSH);
    ld_remain  = src_remain - LEN_W'(size_c);
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    len_d     = len_q;
    beat_d    = r_hs ? beat_q + LEN_W'(1) : beat_q;
    out_d     = out_q + CNT_W'(ar_hs) - CNT_W'(r_last_hs);
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    done_d    = 1'b0;
`ifdef DDR_RD_RRESP_CHECK_EN
    rd_err_d  = rd_err_q | (r_hs & (m_rresp != 2'b00));
`else
    rd_err_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          len_d  = cmd_len;
          beat_d = '0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ISSUE;
            arvalid_d = 1'b1;
            araddr_d  = src_addr;
            arlen_d   = 8'(size_c - SIZE_W'(1));
            addr_d    = ld_next;
            remain_d  = ld_remain;
          end
        end
      end
      ISSUE: begin
        if (ar_hs) arvalid_d = 1'b0;
        if (remain_q == '0) begin
          if (ar_hs) state_d = DRAIN;
        end else if ((!arvalid_q || ar_hs) && (out_d < CNT_W'(MAX_OUTSTANDING))) begin
          arvalid_d = 1'b1;
          araddr_d  = src_addr;
          arlen_d   = 8'(size_c - SIZE_W'(1));
          addr_d    = ld_next;
          remain_d  = ld_remain;
        end
      end
      DRAIN: begin
        if (final_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef DDR_RD_RRESP_CHECK_EN
  logic unused_rresp;
  assign unused_rresp = ^m_rresp;
`endif

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge core_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      out_q     <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      done_q    <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      out_q     <= out_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      done_q    <= done_d;
      rd_err_q  <= rd_err_d;
    end
  end

endmodule
